ca_code_nco: RTL and testbench
==============================

// Module: ca_code_nco
// PURPOSE
//  Code-rate NCO directly upstream of the C/A code generator. Produces the half-chip clock enables caclki/caclkq
//  (on-time and half-chip-late) that step the Gold-code registers and the dither delay line, tracks chip position
//  mod 1023, and supports controlled code-phase slew (advance/retard in half-chips) for acquisition/tracking.
// PARAMETERS
//  ACC_W   32  phase accumulator width; one carry-out = one half-chip tick
//  SLEW_W  11  width of slew amount in half-chips (max 2047)
// PORTS
//  clk         in   1       system clock
//  rst         in   1       synchronous, active-high reset
//  en          in   1       1 = NCO runs; 0 = everything (acc, FSM, counters) holds, no pulses
//  freq_word   in   ACC_W   phase increment per clk (half-chip rate * 2^ACC_W / f_clk)
//  freq_load   in   1       latch freq_word into freq_r at this edge
//  slew_req    in   1       start slew (accepted only in IDLE)
//  slew_dir    in   1       1 = advance (insert ticks), 0 = retard (suppress ticks)
//  slew_amt    in   SLEW_W  slew size in half-chips
//  caclki      out  1       1-cycle pulse: on-time chip edge
//  caclkq      out  1       1-cycle pulse: half-chip-late edge
//  chip_cnt    out  10      count of emitted caclki pulses, mod 1023
//  chip_wrap   out  1       1-cycle pulse, coincident with caclki that takes chip_cnt 1022->0
//  phase_out   out  ACC_W   current accumulator value (for DLL discriminator)
//  slew_busy   out  1       high while slew in progress
//  slew_done   out  1       1-cycle pulse at slew completion
// BEHAVIOUR
//  Reset: acc=0, freq_r=0, half-phase h=0, chip_cnt=0, FSM=IDLE; all outputs 0.
//  Accumulator (en=1): acc <= acc + freq_r, modulo 2^ACC_W; carry-out = natural tick. At most one carry per cycle.
//  freq_load: freq_r <= freq_word at that edge; new value used from next add. Allowed at any time, incl. during slew.
//  Tick emission (registered, 1 cycle after carry): h=0 -> caclki=1, h<=1; h=1 -> caclkq=1, h<=0.
//    Never caclki and caclkq in the same cycle; at most one emitted tick per cycle.
//  chip_cnt increments at same edge caclki asserts; 1022 -> 0 with chip_wrap=1.
//  Slew FSM states IDLE, ADVANCE, RETARD, DONE:
//   IDLE: slew_req=1 & en=1 -> rem<=slew_amt, slew_busy=1; dir=1 -> ADVANCE, dir=0 -> RETARD.
//         slew_amt=0 -> DONE directly (no tick change).
//   ADVANCE: in every enabled cycle with no natural carry, insert one tick (same h/chip_cnt rules), rem--;
//            natural ticks still emitted. rem reaches 0 -> DONE.
//   RETARD: each natural carry is suppressed (no pulse, h and chip_cnt unchanged), rem--; rem reaches 0 -> DONE.
//   DONE: slew_done=1 for one cycle, slew_busy=0 -> IDLE.
//   slew_req while busy or in DONE ignored. en=0 freezes FSM and rem.
//  Net effect: advance N shifts code by +N half-chips vs unslewed run; retard N by -N. h parity follows tick count.
//  Reset mid-slew: FSM->IDLE, busy=0, no slew_done, pending slew discarded.
//  phase_out is the registered acc (post-add value).
// TESTING
//  1 rst; freq 2^30 (ACC_W=32), en=1 -> tick every 4 clks; caclki every 8; caclkq 4 clks after each caclki;
//    first caclki one cycle after 4th enabled edge.
//  2 freq 2^30, advance slew_amt=6 -> 6 extra pulses within ~8 clks; chip_cnt +3 vs golden run; one slew_done;
//    busy then low.
//  3 freq 2^30, retard slew_amt=4 -> next 4 natural ticks absent (16 clks); chip_cnt -2 vs golden; h parity
//    unchanged; slew_done once.
//  4 freq 2^31 -> 2046 ticks give exactly one chip_wrap with caclki, chip_cnt 1022->0; period 4092 clks.
//  5 assert rst during ADVANCE with rem=3 -> next cycle all outputs 0, busy=0, no slew_done; slew_req during
//    busy ignored; slew_amt=0 -> slew_done next-but-one cycle, tick timing unchanged.
//  6 en=0 for 10 clks mid-run -> no pulses, phase_out/chip_cnt frozen; resume continues exact sequence;
//    freq_load 2^29 -> tick spacing 8 clks from next add.

Source files
------------

// File: rtl/ca_code_nco.sv
// Code-rate NCO feeding the C/A code generator: half-chip enables, chip position mod 1023,
// and half-chip code-phase slew (advance inserts ticks, retard swallows natural ticks).
module ca_code_nco #(
    parameter int ACC_W  = 32,
    parameter int SLEW_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ACC_W-1:0]  freq_word,
    input  logic              freq_load,
    input  logic              slew_req,
    input  logic              slew_dir,
    input  logic [SLEW_W-1:0] slew_amt,
    output logic              caclki,
    output logic              caclkq,
    output logic [9:0]        chip_cnt,
    output logic              chip_wrap,
    output logic [ACC_W-1:0]  phase_out,
    output logic              slew_busy,
    output logic              slew_done,
    output logic [1:0]        slew_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADVANCE = 2'd1,
        S_RETARD  = 2'd2,
        S_DONE    = 2'd3
    } slew_state_t;

    slew_state_t       state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  freq_q;
    logic              carry_q;
    logic              h_q;
    logic [9:0]        chip_cnt_q;
    logic [SLEW_W-1:0] rem_q;
    logic              caclki_q;
    logic              caclkq_q;
    logic              chip_wrap_q;
    logic              slew_busy_q;
    logic              slew_done_q;

    logic [ACC_W:0]    sum_d;
    logic              carry_d;
    logic              emit_d;
    logic              emit_i_d;
    logic              last_chip_d;

    assign sum_d   = {1'b0, acc_q} + {1'b0, freq_q};
    assign carry_d = sum_d[ACC_W];

    // carry_q is the natural tick, one cycle behind the wrap; advance fills every gap, retard swallows it
    assign emit_d = (state_q == S_ADVANCE) ? 1'b1 :
                    (state_q == S_RETARD)  ? 1'b0 : carry_q;
    assign emit_i_d    = emit_d & ~h_q;
    assign last_chip_d = (chip_cnt_q == 10'd1022);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            freq_q      <= '0;
            carry_q     <= 1'b0;
            h_q         <= 1'b0;
            chip_cnt_q  <= '0;
            rem_q       <= '0;
            caclki_q    <= 1'b0;
            caclkq_q    <= 1'b0;
            chip_wrap_q <= 1'b0;
            slew_busy_q <= 1'b0;
            slew_done_q <= 1'b0;
        end else begin
            if (freq_load) begin
                freq_q <= freq_word;
            end
            if (en) begin
                acc_q       <= sum_d[ACC_W-1:0];
                carry_q     <= carry_d;
                caclki_q    <= emit_i_d;
                caclkq_q    <= emit_d & h_q;
                chip_wrap_q <= emit_i_d & last_chip_d;
                slew_done_q <= (state_q == S_DONE);
                if (emit_d) begin
                    h_q <= ~h_q;
                end
                if (emit_i_d) begin
                    chip_cnt_q <= last_chip_d ? 10'd0 : chip_cnt_q + 10'd1;
                end
                case (state_q)
                    S_IDLE: begin
                        if (slew_req) begin
                            rem_q <= slew_amt;
                            if (slew_amt == '0) begin
                                state_q <= S_DONE;
                            end else begin
                                slew_busy_q <= 1'b1;
                                state_q     <= slew_dir ? S_ADVANCE : S_RETARD;
                            end
                        end
                    end
                    S_ADVANCE: begin
                        if (!carry_q) begin
                            rem_q <= rem_q - SLEW_W'(1);
                            if (rem_q == SLEW_W'(1)) begin
                                slew_busy_q <= 1'b0;
                                state_q     <= S_DONE;
                            end
                        end
                    end
                    S_RETARD: begin
                        if (carry_q) begin
                            rem_q <= rem_q - SLEW_W'(1);
                            if (rem_q == SLEW_W'(1)) begin
                                slew_busy_q <= 1'b0;
                                state_q     <= S_DONE;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end else begin
                caclki_q    <= 1'b0;
                caclkq_q    <= 1'b0;
                chip_wrap_q <= 1'b0;
                slew_done_q <= 1'b0;
            end
        end
    end

    assign caclki     = caclki_q;
    assign caclkq     = caclkq_q;
    assign chip_cnt   = chip_cnt_q;
    assign chip_wrap  = chip_wrap_q;
    assign phase_out  = acc_q;
    assign slew_busy  = slew_busy_q;
    assign slew_done  = slew_done_q;
    assign slew_state = state_q;

endmodule

// File: tb/tb_ca_code_nco.sv
// Directed bench for ca_code_nco: tick cadence, advance/retard slew, chip wrap, reset mid-slew, enable gating.
module tb_ca_code_nco;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] freq_word;
    logic        freq_load;
    logic        slew_req;
    logic        slew_dir;
    logic [10:0] slew_amt;
    logic        caclki;
    logic        caclkq;
    logic [9:0]  chip_cnt;
    logic        chip_wrap;
    logic [31:0] phase_out;
    logic        slew_busy;
    logic        slew_done;
    logic [1:0]  slew_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    // advance-6 window, cycles 7..17
    int t2_ci[11]   = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    int t2_cq[11]   = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
    int t2_busy[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    int t2_done[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    ca_code_nco #(.ACC_W(32), .SLEW_W(11)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .freq_word  (freq_word),
        .freq_load  (freq_load),
        .slew_req   (slew_req),
        .slew_dir   (slew_dir),
        .slew_amt   (slew_amt),
        .caclki     (caclki),
        .caclkq     (caclkq),
        .chip_cnt   (chip_cnt),
        .chip_wrap  (chip_wrap),
        .phase_out  (phase_out),
        .slew_busy  (slew_busy),
        .slew_done  (slew_done),
        .slew_state (slew_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pulse(input string t, input int k, input int wi, input int wq);
        check($sformatf("%s_ci_k%0d", t, k), 32'(caclki), 32'(wi));
        check($sformatf("%s_cq_k%0d", t, k), 32'(caclkq), 32'(wq));
    endtask

    // reset, load frequency with en low, then enable; the next step() is enabled edge 1
    task automatic start(input logic [31:0] f);
        rst = 1'b1; en = 1'b0; slew_req = 1'b0; freq_load = 1'b0;
        step();
        step();
        rst = 1'b0;
        freq_word = f;
        freq_load = 1'b1;
        step();
        freq_load = 1'b0;
        en = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; freq_word = '0; freq_load = 1'b0;
        slew_req = 1'b0; slew_dir = 1'b0; slew_amt = '0;

        // reset state
        step();
        step();
        check("rst_ci", 32'(caclki), 0);
        check("rst_cq", 32'(caclkq), 0);
        check("rst_chip", 32'(chip_cnt), 0);
        check("rst_phase", phase_out, 0);
        check("rst_busy", 32'(slew_busy), 0);
        check("rst_done", 32'(slew_done), 0);

        // 1: quarter-rate ticks, caclki every 8, caclkq 4 later
        start(32'h4000_0000);
        exp_q = {};
        exp_q.push_back(5);
        exp_q.push_back(13);
        exp_q.push_back(21);
        for (int k = 1; k <= 24; k++) begin
            step();
            check($sformatf("t1_phase_k%0d", k), phase_out, 32'(k) << 30);
            check($sformatf("t1_cq_k%0d", k), 32'(caclkq), 32'((k >= 9) && ((k - 9) % 8 == 0)));
            if (caclki) begin
                if (exp_q.size() > 0) check("t1_ci_at", 32'(k), exp_q.pop_front());
                else check("t1_ci_extra", 32'(k), 0);
            end
        end
        check("t1_pending", 32'(exp_q.size()), 0);
        check("t1_chip", 32'(chip_cnt), 3);

        // 2: advance 6 half-chips
        start(32'h4000_0000);
        run(6);
        slew_req = 1'b1; slew_dir = 1'b1; slew_amt = 11'd6;
        for (int k = 7; k <= 17; k++) begin
            step();
            slew_req = 1'b0;
            chk_pulse("t2", k, t2_ci[k-7], t2_cq[k-7]);
            check($sformatf("t2_busy_k%0d", k), 32'(slew_busy), 32'(t2_busy[k-7]));
            check($sformatf("t2_done_k%0d", k), 32'(slew_done), 32'(t2_done[k-7]));
        end
        check("t2_chip", 32'(chip_cnt), 5);

        // 3: retard 4 half-chips
        start(32'h4000_0000);
        run(6);
        slew_req = 1'b1; slew_dir = 1'b0; slew_amt = 11'd4;
        for (int k = 7; k <= 25; k++) begin
            step();
            slew_req = 1'b0;
            chk_pulse("t3", k, 0, (k == 25) ? 1 : 0);
            check($sformatf("t3_busy_k%0d", k), 32'(slew_busy), 32'(k <= 20));
            check($sformatf("t3_done_k%0d", k), 32'(slew_done), 32'(k == 22));
        end
        check("t3_chip", 32'(chip_cnt), 1);
        run(4);
        chk_pulse("t3", 29, 1, 0);
        check("t3_chip_after", 32'(chip_cnt), 2);

        // 4: half-rate ticks, chip wrap every 4092 clks
        start(32'h8000_0000);
        exp_q = {};
        exp_q.push_back(4091);
        exp_q.push_back(8183);
        for (int k = 1; k <= 8185; k++) begin
            step();
            if (k == 4090) check("t4_chip_pre", 32'(chip_cnt), 1022);
            if (chip_wrap) begin
                check("t4_wrap_ci", 32'(caclki), 1);
                check("t4_wrap_chip", 32'(chip_cnt), 0);
                if (exp_q.size() > 0) check("t4_wrap_at", 32'(k), exp_q.pop_front());
                else check("t4_wrap_extra", 32'(k), 0);
            end
        end
        check("t4_pending", 32'(exp_q.size()), 0);

        // 5a: reset during advance with 3 remaining; request while busy ignored
        start(32'h4000_0000);
        run(6);
        slew_req = 1'b1; slew_dir = 1'b1; slew_amt = 11'd6;
        step();
        slew_req = 1'b0;
        step();
        slew_req = 1'b1; slew_dir = 1'b0; slew_amt = 11'd2;
        step();
        slew_req = 1'b0;
        step();
        chk_pulse("t5", 10, 0, 1);
        step();
        check("t5_state_adv", 32'(slew_state), 1);
        check("t5_busy_pre", 32'(slew_busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_pulse("t5_rst", 12, 0, 0);
        check("t5_rst_chip", 32'(chip_cnt), 0);
        check("t5_rst_wrap", 32'(chip_wrap), 0);
        check("t5_rst_phase", phase_out, 0);
        check("t5_rst_busy", 32'(slew_busy), 0);
        check("t5_rst_done", 32'(slew_done), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t5_post_done_%0d", i), 32'(slew_done), 0);
            check($sformatf("t5_post_busy_%0d", i), 32'(slew_busy), 0);
        end

        // 5b: zero-size slew
        start(32'h4000_0000);
        run(6);
        slew_req = 1'b1; slew_dir = 1'b1; slew_amt = 11'd0;
        for (int k = 7; k <= 13; k++) begin
            step();
            slew_req = 1'b0;
            chk_pulse("t5z", k, (k == 13) ? 1 : 0, (k == 9) ? 1 : 0);
            check($sformatf("t5z_busy_k%0d", k), 32'(slew_busy), 0);
            check($sformatf("t5z_done_k%0d", k), 32'(slew_done), 32'(k == 8));
        end

        // 6: enable gating, then frequency change
        start(32'h4000_0000);
        run(6);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_pulse("t6_off", i, 0, 0);
            check($sformatf("t6_off_phase_%0d", i), phase_out, 32'h8000_0000);
            check($sformatf("t6_off_chip_%0d", i), 32'(chip_cnt), 1);
        end
        en = 1'b1;
        for (int k = 7; k <= 14; k++) begin
            step();
            chk_pulse("t6_on", k, (k == 13) ? 1 : 0, (k == 9) ? 1 : 0);
            if (k == 13) begin
                freq_word = 32'h2000_0000;
                freq_load = 1'b1;
            end else begin
                freq_load = 1'b0;
            end
        end
        check("t6_phase_k14", phase_out, 32'h8000_0000);
        for (int k = 15; k <= 28; k++) begin
            step();
            chk_pulse("t6_slow", k, (k == 27) ? 1 : 0, (k == 19) ? 1 : 0);
            if (k == 18) check("t6_phase_k18", phase_out, 0);
            if (k == 19) check("t6_phase_k19", phase_out, 32'h2000_0000);
        end
        check("t6_chip", 32'(chip_cnt), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
